// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared grant/source encodings, the read-return tag type
// and the legal parameter ranges for the data-memory arbiter.
package dmem_arbiter_pkg;

    // Which requester owns the memory port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_CPU  = 2'd1,
        GNT_PER  = 2'd2
    } gnt_e;

    // Which requester an in-flight read belongs to
    localparam logic SRC_CPU = 1'b0;
    localparam logic SRC_PER = 1'b1;

    // Supported memory read latency and starvation limit
    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 4;
    localparam int STARVE_MAX_MIN = 1;
    localparam int STARVE_MAX_MAX = 15;

    // One in-flight read: valid flag plus originating requester
    typedef struct packed {
        logic v;
        logic src;
    } rd_tag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: cpu, peripheral and dmem signals around the arbiter.
// master = the surrounding system (requesters + memory), slave = arbiter.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              per_req;
    logic [ADDR_W-1:0] per_addr;
    logic              per_gnt;
    logic [DATA_W-1:0] per_rdata;
    logic              per_rvalid;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, per_req, per_addr, mem_q,
        input  cpu_stall, cpu_rdata, cpu_rvalid, per_gnt, per_rdata, per_rvalid,
               mem_addr, mem_wdata, mem_wren
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, per_req, per_addr, mem_q,
        output cpu_stall, cpu_rdata, cpu_rvalid, per_gnt, per_rdata, per_rvalid,
               mem_addr, mem_wdata, mem_wren
    );

endinterface

// File: rtl/dmem_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage {valid, src} delay line that follows each issued
// read through the memory latency so the data lands at the right requester.
module rd_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clock,
    input  logic    reset,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t [DEPTH-1:0] stage;

    // advance tags one stage per cycle; reset drops every read in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stage <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single dmem port between the cpu memory stage and
// a read-only peripheral master. CPU has priority; a 4-bit starvation counter
// forces the peripheral ahead after STARVE_MAX refused cycles. Read returns
// are steered by a tag pipe matching the memory latency.
// Optional: define DMEM_ARB_PERF_EN to add conflict/force perf counters.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clock,
    input  logic        reset,
    dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_conflict_cnt,
    output logic [31:0] perf_force_cnt
`endif
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("dmem_arbiter: RD_LAT out of range");
    end
    if (STARVE_MAX < STARVE_MAX_MIN || STARVE_MAX > STARVE_MAX_MAX) begin : g_bad_starve
        $error("dmem_arbiter: STARVE_MAX out of range");
    end

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    gnt_e              gnt;
    logic              cpu_win;
    logic              per_win;
    logic              force_per;
    logic [3:0]        starve_cnt;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] rdata;
    rd_tag_t           tag_in;
    rd_tag_t           tag_out;

    // peripheral has waited long enough to jump ahead of the cpu
    assign force_per = bus.per_req && (starve_cnt == STARVE_LIM);

    // choose this cycle's owner; nothing is granted while reset is held
    always_comb begin
        gnt = GNT_NONE;
        if (reset) begin
            if (bus.cpu_req && !force_per) gnt = GNT_CPU;
            else if (bus.per_req)          gnt = GNT_PER;
        end
    end

    assign cpu_win = (gnt == GNT_CPU);
    assign per_win = (gnt == GNT_PER);

    // drive the memory port and the request handshakes from the grant
    always_comb begin
        bus.mem_addr = last_addr;
        case (gnt)
            GNT_CPU: bus.mem_addr = bus.cpu_addr;
            GNT_PER: bus.mem_addr = bus.per_addr;
            default: bus.mem_addr = last_addr;
        endcase
        bus.mem_wdata = bus.cpu_wdata;
        bus.mem_wren  = cpu_win && bus.cpu_we;
        bus.cpu_stall = bus.cpu_req && !cpu_win;
        bus.per_gnt   = per_win;
    end

    // count refused peripheral cycles; any grant or idle peripheral clears it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                       starve_cnt <= '0;
        else if (bus.per_req && !per_win) starve_cnt <= (starve_cnt == STARVE_LIM) ? starve_cnt
                                                                                   : starve_cnt + 4'd1;
        else                              starve_cnt <= '0;
    end

    // keep the last issued address so the port is stable on idle cycles
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                last_addr <= '0;
        else if (gnt != GNT_NONE)  last_addr <= bus.mem_addr;
    end

    // stores issue no tag; only reads come back
    always_comb begin
        tag_in.v   = (cpu_win && !bus.cpu_we) || per_win;
        tag_in.src = per_win ? SRC_PER : SRC_CPU;
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_rd_tag_pipe (
        .clock   (clock),
        .reset   (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // memory data fans out to both requesters; rvalid picks the owner
    always_comb begin
        rdata          = bus.mem_q;
        bus.cpu_rdata  = rdata;
        bus.per_rdata  = rdata;
        bus.cpu_rvalid = tag_out.v && (tag_out.src == SRC_CPU);
        bus.per_rvalid = tag_out.v && (tag_out.src == SRC_PER);
    end

`ifdef DMEM_ARB_PERF_EN
    // contention and forced-override event counters, free-running wrap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_conflict_cnt <= '0;
            perf_force_cnt    <= '0;
        end else begin
            if (bus.cpu_req && bus.per_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            if (force_per && bus.cpu_req)   perf_force_cnt    <= perf_force_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + random stimulus with a small grant model; every
// issued read pushes {src, data, due cycle} to a scoreboard that a negedge
// monitor pops when an rvalid appears. A latency-RD_LAT memory model feeds mem_q.
module tb_dmem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int STARVE = 4;

    typedef struct {
        logic        src;
        logic [31:0] data;
        int          due;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    sb_t  sb[$];
    sb_t  mon_e;

    int          m_starve = 0;
    logic [31:0] m_last   = '0;

    logic [31:0]  mem_arr [256];
    logic [255:0] wv;
    logic [31:0]  q_pipe  [RD_LAT];
    logic [31:0]  exp_mem [256];
    logic [255:0] exp_wv;

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
    logic [31:0] perf_force_cnt;
`endif

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt),
        .perf_force_cnt    (perf_force_cnt)
`endif
    );

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:2]);
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'(i * 4) ^ 32'hDEADBEFF;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return exp_wv[idx(a)] ? exp_mem[idx(a)] : pat(idx(a));
    endfunction

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // memory model: writes on wren, read data after RD_LAT cycles
    always @(posedge clock or negedge reset) begin
        if (!reset) wv <= '0;
        else if (bus.mem_wren) begin
            mem_arr[idx(bus.mem_addr)] <= bus.mem_wdata;
            wv[idx(bus.mem_addr)]      <= 1'b1;
        end
    end

    always @(posedge clock) begin
        q_pipe[0] <= wv[idx(bus.mem_addr)] ? mem_arr[idx(bus.mem_addr)] : pat(idx(bus.mem_addr));
        for (int i = 1; i < RD_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    end

    assign bus.mem_q = q_pipe[RD_LAT-1];

    // return monitor: pop scoreboard on rvalid, flag spurious and missing returns
    always @(negedge clock) begin
        if (bus.cpu_rvalid || bus.per_rvalid) begin
            if (sb.size() == 0) begin
                chk("rv_spurious", 64'({bus.cpu_rvalid, bus.per_rvalid}), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                chk("rv_src", 64'({bus.cpu_rvalid, bus.per_rvalid}),
                    mon_e.src ? 64'(2'b01) : 64'(2'b10));
                chk("rv_cycle", 64'(cyc), 64'(mon_e.due));
                chk("rv_data", 64'(mon_e.src ? bus.per_rdata : bus.cpu_rdata), 64'(mon_e.data));
            end
        end else if (sb.size() != 0 && sb[0].due <= cyc) begin
            void'(sb.pop_front());
            chk("rv_missing", 64'(bus.cpu_rvalid | bus.per_rvalid), 64'(1));
        end
    end

    // one cycle of stimulus; checks grant-side outputs against the model
    task automatic step(input logic creq, input logic cwe, input logic [31:0] ca,
                        input logic [31:0] cd, input logic preq, input logic [31:0] pa,
                        output logic g_per, output logic g_stall);
        logic        pw, cw;
        logic [31:0] ea;
        sb_t         e;
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = ca;
        bus.cpu_wdata = cd;
        bus.per_req   = preq;
        bus.per_addr  = pa;
        pw = preq && (!creq || m_starve == STARVE);
        cw = creq && !pw;
        ea = cw ? ca : (pw ? pa : m_last);
        @(negedge clock);
        g_per   = bus.per_gnt;
        g_stall = bus.cpu_stall;
        chk("cpu_stall", 64'(bus.cpu_stall), 64'(creq && !cw));
        chk("per_gnt",   64'(bus.per_gnt),   64'(pw));
        chk("mem_wren",  64'(bus.mem_wren),  64'(cw && cwe));
        chk("mem_addr",  64'(bus.mem_addr),  64'(ea));
        chk("mem_wdata", 64'(bus.mem_wdata), 64'(cd));
        if (pw || (cw && !cwe)) begin
            e.src  = pw;
            e.data = exp_rd(ea);
            e.due  = cyc + RD_LAT;
            sb.push_back(e);
        end
        if (cw && cwe) begin
            exp_mem[idx(ca)] = cd;
            exp_wv[idx(ca)]  = 1'b1;
        end
        if (pw || cw) m_last = ea;
        m_starve = (preq && !pw) ? m_starve + 1 : 0;
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        logic gp, gs;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, gp, gs);
    endtask

    // hold reset one cycle with both requesters active
    task automatic do_reset();
        reset = 1'b0;
        sb.delete();
        m_starve = 0;
        m_last   = '0;
        exp_wv   = '0;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h44;
        bus.cpu_wdata = 32'h99;
        bus.per_req   = 1'b1;
        bus.per_addr  = 32'h50;
        @(negedge clock);
        chk("rst_stall", 64'(bus.cpu_stall), 64'(1));
        chk("rst_gnt",   64'(bus.per_gnt),   64'(0));
        chk("rst_wren",  64'(bus.mem_wren),  64'(0));
        chk("rst_rv",    64'({bus.cpu_rvalid, bus.per_rvalid}), 64'(0));
        chk("rst_addr",  64'(bus.mem_addr),  64'(0));
        @(posedge clock);
        #1;
        bus.cpu_req = 1'b0;
        bus.per_req = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gp, gs;
        logic        cp, pp, cwe_r;
        logic [31:0] ca_r, cd_r, pa_r;

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.per_req = 1'b0; bus.per_addr = '0;
        exp_wv = '0;
        do_reset();

        // first cpu load after reset returns pattern 0xDEADBEEF
        step(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, gp, gs);
        chk("ld10_stall", 64'(gs), 64'(0));
        idle(RD_LAT + 1);

        // alternating cpu / per / cpu reads, no overlap
        step(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0,  gp, gs);
        step(1'b0, 1'b0, 32'h0,  32'h0, 1'b1, 32'h30, gp, gs);
        chk("alt_per_gnt", 64'(gp), 64'(1));
        step(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0,  gp, gs);
        chk("alt_no_stall", 64'(gs), 64'(0));
        idle(RD_LAT + 1);

        // continuous contention: peripheral wins every fifth cycle
        for (int k = 0; k < 15; k++) begin
            step(1'b1, 1'b0, 32'(32'h80 + k * 4), 32'h0, 1'b1, 32'h60, gp, gs);
            chk("starve_gnt",   64'(gp), 64'((k % 5) == 4));
            chk("starve_stall", 64'(gs), 64'((k % 5) == 4));
        end
        idle(RD_LAT + 1);

        // forced peripheral grant holds off a cpu store for one cycle
        for (int k = 0; k < STARVE; k++) step(1'b1, 1'b0, 32'h70, 32'h0, 1'b1, 32'h60, gp, gs);
        step(1'b1, 1'b1, 32'h40, 32'h5, 1'b1, 32'h60, gp, gs);
        chk("force_gnt",   64'(gp), 64'(1));
        chk("force_stall", 64'(gs), 64'(1));
        step(1'b1, 1'b1, 32'h40, 32'h5, 1'b0, 32'h0, gp, gs);
        chk("store_go", 64'(gs), 64'(0));
        step(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, gp, gs);
        idle(RD_LAT + 1);

        // reset while a peripheral read is in flight
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h30, gp, gs);
        do_reset();
        idle(1);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h34, gp, gs);
        idle(RD_LAT + 1);

        // random traffic: requesters hold until accepted
        cp = 1'b0; pp = 1'b0; cwe_r = 1'b0; ca_r = '0; cd_r = '0; pa_r = '0;
        for (int k = 0; k < 80; k++) begin
            if (!cp && $urandom_range(0, 2) != 0) begin
                cp    = 1'b1;
                cwe_r = 1'($urandom_range(0, 1));
                ca_r  = 32'($urandom_range(0, 63)) << 2;
                cd_r  = $urandom;
            end
            if (!pp && $urandom_range(0, 1) != 0) begin
                pp   = 1'b1;
                pa_r = 32'($urandom_range(0, 63)) << 2;
            end
            step(cp, cwe_r, ca_r, cd_r, pp, pa_r, gp, gs);
            if (cp && !gs) cp = 1'b0;
            if (pp && gp)  pp = 1'b0;
        end
        idle(RD_LAT + 1);

`ifdef DMEM_ARB_PERF_EN
        do_reset();
        chk("perf_conf_rst",  64'(perf_conflict_cnt), 64'(0));
        chk("perf_force_rst", 64'(perf_force_cnt),    64'(0));
        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 32'h60, gp, gs);
        chk("perf_conf",  64'(perf_conflict_cnt), 64'(10));
        chk("perf_force", 64'(perf_force_cnt),    64'(2));
        idle(RD_LAT + 1);
`endif

        idle(RD_LAT + 2);
        chk("sb_drain", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
